// File: rtl/l1i_cache_if.sv
// Fetch request, refill and fetch-result signals of the L1 instruction cache.
// The master drives requests and refills; the cache (slave) returns instructions and misses.
interface l1i_cache_if #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LineWidth   = 512,
    parameter int unsigned InstrWidth  = 32,
    parameter int unsigned OffsetWidth = 6,
    parameter int unsigned IndexWidth  = 8,
    parameter int unsigned TagWidth    = 50,
    parameter int unsigned PidSize     = 20,
    parameter int unsigned TidSize     = 16,
    parameter int unsigned IdWidth     = 64
);
    logic                   fetchEnable_i;
    logic                   fetchStall_i;
    logic [PidSize-1:0]     Pid_i;
    logic [TidSize-1:0]     Tid_i;
    logic [TagWidth-1:0]    tag_i;
    logic [IndexWidth-1:0]  index_i;
    logic [OffsetWidth-1:0] offset_i;

    logic                   cacheUpdate_i;
    logic [AddrWidth-1:0]   cacheUpdateAddress_i;
    logic [PidSize-1:0]     cacheUpdatePid_i;
    logic [TidSize-1:0]     cacheUpdateTid_i;
    logic [LineWidth-1:0]   cacheUpdateLine1_i;
    logic [LineWidth-1:0]   cacheUpdateLine2_i;

    logic                   fetchEnable1_o;
    logic                   fetchEnable2_o;
    logic [InstrWidth-1:0]  fetchedInstruction1_o;
    logic [InstrWidth-1:0]  fetchedInstruction2_o;
    logic [AddrWidth-1:0]   fetchedAddress1_o;
    logic [AddrWidth-1:0]   fetchedAddress2_o;
    logic [PidSize-1:0]     fetchedPid1_o;
    logic [TidSize-1:0]     fetchedTid1_o;
    logic [PidSize-1:0]     fetchedPid2_o;
    logic [TidSize-1:0]     fetchedTid2_o;
    logic [IdWidth-1:0]     fetchedInstMajorId1_o;
    logic [IdWidth-1:0]     fetchedInstMajorId2_o;

    logic                   cacheMiss_o;
    logic [AddrWidth-1:0]   missedAddress_o;
    logic [IdWidth-1:0]     missedInstMajorId_o;
    logic [PidSize-1:0]     missedPid_o;
    logic [TidSize-1:0]     missedTid_o;

    modport master (
        output fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
        output cacheUpdate_i, cacheUpdateAddress_i, cacheUpdatePid_i, cacheUpdateTid_i,
        output cacheUpdateLine1_i, cacheUpdateLine2_i,
        input  fetchEnable1_o, fetchEnable2_o, fetchedInstruction1_o, fetchedInstruction2_o,
        input  fetchedAddress1_o, fetchedAddress2_o, fetchedPid1_o, fetchedTid1_o,
        input  fetchedPid2_o, fetchedTid2_o, fetchedInstMajorId1_o, fetchedInstMajorId2_o,
        input  cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o
    );

    modport slave (
        input  fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
        input  cacheUpdate_i, cacheUpdateAddress_i, cacheUpdatePid_i, cacheUpdateTid_i,
        input  cacheUpdateLine1_i, cacheUpdateLine2_i,
        output fetchEnable1_o, fetchEnable2_o, fetchedInstruction1_o, fetchedInstruction2_o,
        output fetchedAddress1_o, fetchedAddress2_o, fetchedPid1_o, fetchedTid1_o,
        output fetchedPid2_o, fetchedTid2_o, fetchedInstMajorId1_o, fetchedInstMajorId2_o,
        output cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o
    );
endinterface

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache: 3-stage pipeline (latch, array read, hit/miss)
// delivering two consecutive big-endian instructions per hit, blocking on a miss until refill.
module l1i_cache #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LineWidth   = 512,
    parameter int unsigned InstrWidth  = 32,
    parameter int unsigned OffsetWidth = 6,
    parameter int unsigned IndexWidth  = 8,
    parameter int unsigned TagWidth    = 50,
    parameter int unsigned PidSize     = 20,
    parameter int unsigned TidSize     = 16,
    parameter int unsigned IdWidth     = 64
) (
    input logic        clock_i,
    input logic        cacheReset_i,
    l1i_cache_if.slave bus
);
    localparam int unsigned NumLines = 1 << IndexWidth;
    localparam int unsigned LaWidth  = AddrWidth - OffsetWidth;
    localparam int unsigned WordSelW = $clog2(LineWidth / InstrWidth);
    localparam logic [AddrWidth-1:0] InstrBytes = AddrWidth'(InstrWidth / 8);

    typedef enum logic [0:0] {StFetch, StStalled} state_e;

    // Word 0 sits in the most significant bits of a line.
    function automatic logic [InstrWidth-1:0] word_of(input logic [LineWidth-1:0] line,
                                                      input logic [WordSelW-1:0] k);
        logic [LineWidth-1:0] sh;
        sh = line << (InstrWidth * int'(k));
        return sh[LineWidth-1 -: InstrWidth];
    endfunction

    logic [NumLines-1:0]  valid_q;
    logic [TagWidth-1:0]  tag_q  [NumLines];
    logic [LineWidth-1:0] data_q [NumLines];

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   counter_q, counter_d;
    logic                 advance, miss, accept;

    logic                 s1_valid_q;
    logic [AddrWidth-1:0] s1_addr_q;
    logic [PidSize-1:0]   s1_pid_q;
    logic [TidSize-1:0]   s1_tid_q;

    logic                  s2_valid_q, s2_hit1_q, s2_hit2_q;
    logic [AddrWidth-1:0]  s2_addr_q;
    logic [PidSize-1:0]    s2_pid_q;
    logic [TidSize-1:0]    s2_tid_q;
    logic [InstrWidth-1:0] s2_word1_q, s2_word2_q;

    logic                  en1_q, en2_q, miss_q;
    logic [InstrWidth-1:0] instr1_q, instr2_q;
    logic [AddrWidth-1:0]  addr1_q, addr2_q, missed_addr_q;
    logic [PidSize-1:0]    pid_q, missed_pid_q;
    logic [TidSize-1:0]    tid_q, missed_tid_q;
    logic [IdWidth-1:0]    id1_q, id2_q, missed_id_q;

    // Refill: line 2 goes to the following line address, so the tag bumps on index wrap.
    logic [LaWidth-1:0]    upd_la1, upd_la2;
    assign upd_la1 = bus.cacheUpdateAddress_i[AddrWidth-1:OffsetWidth];
    assign upd_la2 = upd_la1 + LaWidth'(1);

    logic [AddrWidth-1:0]  req_addr, s1_addr2;
    logic [LaWidth-1:0]    rd_la1, rd_la2;
    logic [IndexWidth-1:0] rd_idx1, rd_idx2;
    logic                  rd_hit1, rd_hit2;
    logic [InstrWidth-1:0] rd_word1, rd_word2;

    assign req_addr = {bus.tag_i, bus.index_i, bus.offset_i};
    assign s1_addr2 = s1_addr_q + InstrBytes;
    assign rd_la1   = s1_addr_q[AddrWidth-1:OffsetWidth];
    assign rd_la2   = s1_addr2[AddrWidth-1:OffsetWidth];
    assign rd_idx1  = rd_la1[IndexWidth-1:0];
    assign rd_idx2  = rd_la2[IndexWidth-1:0];
    assign rd_hit1  = valid_q[rd_idx1] && (tag_q[rd_idx1] == rd_la1[LaWidth-1:IndexWidth]);
    assign rd_hit2  = valid_q[rd_idx2] && (tag_q[rd_idx2] == rd_la2[LaWidth-1:IndexWidth]);
    assign rd_word1 = word_of(data_q[rd_idx1], s1_addr_q[OffsetWidth-1 -: WordSelW]);
    assign rd_word2 = word_of(data_q[rd_idx2], s1_addr2[OffsetWidth-1 -: WordSelW]);

    logic unused_ok;
    assign unused_ok = ^{bus.cacheUpdatePid_i, bus.cacheUpdateTid_i, s1_addr2[1:0],
                         bus.cacheUpdateAddress_i[OffsetWidth-1:0]};

    always_comb begin
        advance   = !bus.fetchStall_i;
        miss      = advance && s2_valid_q && !s2_hit1_q;
        // A miss squashes everything younger, including a request arriving on that edge.
        accept    = advance && bus.fetchEnable_i && (state_q == StFetch) && !miss;
        state_d   = state_q;
        counter_d = counter_q;
        unique case (state_q)
            StFetch:   if (miss) state_d = StStalled;
            StStalled: if (bus.cacheUpdate_i) state_d = StFetch;
            default:   state_d = StFetch;
        endcase
        if (advance && s2_valid_q && s2_hit1_q) begin
            counter_d = counter_q + IdWidth'(s2_hit2_q ? 2 : 1);
        end
    end

    always_ff @(posedge clock_i or negedge cacheReset_i) begin
        if (!cacheReset_i) begin
            valid_q <= '0;
        end else if (bus.cacheUpdate_i) begin
            valid_q[upd_la1[IndexWidth-1:0]] <= 1'b1;
            valid_q[upd_la2[IndexWidth-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (bus.cacheUpdate_i) begin
            tag_q[upd_la1[IndexWidth-1:0]]  <= upd_la1[LaWidth-1:IndexWidth];
            tag_q[upd_la2[IndexWidth-1:0]]  <= upd_la2[LaWidth-1:IndexWidth];
            data_q[upd_la1[IndexWidth-1:0]] <= bus.cacheUpdateLine1_i;
            data_q[upd_la2[IndexWidth-1:0]] <= bus.cacheUpdateLine2_i;
        end
    end

    always_ff @(posedge clock_i or negedge cacheReset_i) begin
        if (!cacheReset_i) begin
            state_q    <= StFetch;
            counter_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_pid_q   <= '0;
            s1_tid_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_hit1_q  <= 1'b0;
            s2_hit2_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_pid_q   <= '0;
            s2_tid_q   <= '0;
            s2_word1_q <= '0;
            s2_word2_q <= '0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            miss_q     <= 1'b0;
            instr1_q   <= '0;
            instr2_q   <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            pid_q      <= '0;
            tid_q      <= '0;
            id1_q      <= '0;
            id2_q      <= '0;
            missed_addr_q <= '0;
            missed_id_q   <= '0;
            missed_pid_q  <= '0;
            missed_tid_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            if (advance) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_addr_q <= req_addr;
                    s1_pid_q  <= bus.Pid_i;
                    s1_tid_q  <= bus.Tid_i;
                end
                s2_valid_q <= s1_valid_q && !miss;
                if (s1_valid_q) begin
                    s2_addr_q  <= s1_addr_q;
                    s2_pid_q   <= s1_pid_q;
                    s2_tid_q   <= s1_tid_q;
                    s2_hit1_q  <= rd_hit1;
                    s2_hit2_q  <= rd_hit2;
                    s2_word1_q <= rd_word1;
                    s2_word2_q <= rd_word2;
                end
                en1_q  <= s2_valid_q && s2_hit1_q;
                en2_q  <= s2_valid_q && s2_hit1_q && s2_hit2_q;
                miss_q <= miss;
                if (s2_valid_q && s2_hit1_q) begin
                    instr1_q <= s2_word1_q;
                    instr2_q <= s2_word2_q;
                    addr1_q  <= s2_addr_q;
                    addr2_q  <= s2_addr_q + InstrBytes;
                    pid_q    <= s2_pid_q;
                    tid_q    <= s2_tid_q;
                    id1_q    <= counter_q;
                    id2_q    <= counter_q + IdWidth'(1);
                end
                if (miss) begin
                    missed_addr_q <= s2_addr_q;
                    missed_id_q   <= counter_q;
                    missed_pid_q  <= s2_pid_q;
                    missed_tid_q  <= s2_tid_q;
                end
            end
        end
    end

    assign bus.fetchEnable1_o        = en1_q;
    assign bus.fetchEnable2_o        = en2_q;
    assign bus.fetchedInstruction1_o = instr1_q;
    assign bus.fetchedInstruction2_o = instr2_q;
    assign bus.fetchedAddress1_o     = addr1_q;
    assign bus.fetchedAddress2_o     = addr2_q;
    assign bus.fetchedPid1_o         = pid_q;
    assign bus.fetchedTid1_o         = tid_q;
    assign bus.fetchedPid2_o         = pid_q;
    assign bus.fetchedTid2_o         = tid_q;
    assign bus.fetchedInstMajorId1_o = id1_q;
    assign bus.fetchedInstMajorId2_o = id2_q;
    assign bus.cacheMiss_o           = miss_q;
    assign bus.missedAddress_o       = missed_addr_q;
    assign bus.missedInstMajorId_o   = missed_id_q;
    assign bus.missedPid_o           = missed_pid_q;
    assign bus.missedTid_o           = missed_tid_q;
endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache: per-cycle vector table plus hand sequences for
// fetch stall and asynchronous reset in the middle of a fetch.
module tb_l1i_cache;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1i_cache_if bus ();
    l1i_cache dut (.clock_i(clk), .cacheReset_i(rst_n), .bus(bus));

    localparam logic [19:0] ReqPid = 20'h12345;
    localparam logic [15:0] ReqTid = 16'hBEEF;

    typedef struct {
        bit          fe;
        logic [49:0] tag;
        logic [7:0]  idx;
        logic [5:0]  off;
        bit          upd;
        logic [63:0] ua;
        bit          e1;
        bit          e2;
        bit          miss;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [63:0] a1;
        logic [63:0] id1;
    } vec_t;

    vec_t vecs[24];
    int total = 0;
    int bad   = 0;
    logic [511:0] line1, line2;

    function automatic logic [31:0] w1(int k);
        case (k)
            0: return 32'hAAAAAAAA;
            1: return 32'hBBBBBBBB;
            2: return 32'hCCCCCCCC;
            3, 15: return 32'hDDDDDDDD;
            default: return 32'h50000000 + 32'(k);
        endcase
    endfunction

    function automatic logic [31:0] w2(int k);
        return (k == 0) ? 32'hEEEEEEEE : 32'hE0000000 + 32'(k);
    endfunction

    function automatic vec_t mk(bit fe, logic [49:0] tag, logic [7:0] idx, logic [5:0] off,
                                bit upd, logic [63:0] ua, bit e1, bit e2, bit miss,
                                logic [31:0] i1, logic [31:0] i2, logic [63:0] a1,
                                logic [63:0] id1);
        vec_t v;
        v.fe = fe; v.tag = tag; v.idx = idx; v.off = off; v.upd = upd; v.ua = ua;
        v.e1 = e1; v.e2 = e2; v.miss = miss; v.i1 = i1; v.i2 = i2; v.a1 = a1; v.id1 = id1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit fe, input logic [49:0] tag, input logic [7:0] idx,
                         input logic [5:0] off, input bit upd, input logic [63:0] ua);
        bus.fetchEnable_i        = fe;
        bus.tag_i                = tag;
        bus.index_i              = idx;
        bus.offset_i             = off;
        bus.cacheUpdate_i        = upd;
        bus.cacheUpdateAddress_i = ua;
    endtask

    task automatic check_vec(input string n, input vec_t v);
        chk({n, ".en1"}, 64'(bus.fetchEnable1_o), 64'(v.e1));
        chk({n, ".en2"}, 64'(bus.fetchEnable2_o), 64'(v.e2));
        chk({n, ".miss"}, 64'(bus.cacheMiss_o), 64'(v.miss));
        if (v.e1) begin
            chk({n, ".inst1"}, 64'(bus.fetchedInstruction1_o), 64'(v.i1));
            chk({n, ".addr1"}, bus.fetchedAddress1_o, v.a1);
            chk({n, ".id1"}, bus.fetchedInstMajorId1_o, v.id1);
            chk({n, ".pid1"}, 64'(bus.fetchedPid1_o), 64'(ReqPid));
            chk({n, ".tid1"}, 64'(bus.fetchedTid1_o), 64'(ReqTid));
        end
        if (v.e2) begin
            chk({n, ".inst2"}, 64'(bus.fetchedInstruction2_o), 64'(v.i2));
            chk({n, ".addr2"}, bus.fetchedAddress2_o, v.a1 + 64'd4);
            chk({n, ".id2"}, bus.fetchedInstMajorId2_o, v.id1 + 64'd1);
        end
        if (v.miss) begin
            chk({n, ".maddr"}, bus.missedAddress_o, v.a1);
            chk({n, ".mid"}, bus.missedInstMajorId_o, v.id1);
            chk({n, ".mpid"}, 64'(bus.missedPid_o), 64'(ReqPid));
            chk({n, ".mtid"}, 64'(bus.missedTid_o), 64'(ReqTid));
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            line1[511 - 32 * k -: 32] = w1(k);
            line2[511 - 32 * k -: 32] = w2(k);
        end
        bus.fetchStall_i       = 1'b0;
        bus.Pid_i              = ReqPid;
        bus.Tid_i              = ReqTid;
        bus.cacheUpdatePid_i   = 20'h1;
        bus.cacheUpdateTid_i   = 16'h2;
        bus.cacheUpdateLine1_i = line1;
        bus.cacheUpdateLine2_i = line2;
        drive(1'b0, '0, '0, '0, 1'b0, '0);

        // Cycle-by-cycle: inputs for one edge, outputs expected right after it.
        vecs[0]  = mk(1, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 64'd4, 64'd0);
        vecs[3]  = mk(1, 0, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0,  1, 64'd4, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 0, 32'hCCCCCCCC, 32'hDDDDDDDD, 64'd8, 64'd0);
        vecs[10] = mk(1, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 24, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 32, 0, 0, 1, 1, 0, 32'h50000004, 32'h50000005, 64'd16, 64'd2);
        vecs[13] = mk(1, 0, 0, 60, 0, 0, 1, 1, 0, 32'h50000006, 32'h50000007, 64'd24, 64'd4);
        vecs[14] = mk(1, 0, 1, 60, 0, 0, 1, 1, 0, 32'h50000008, 32'h50000009, 64'd32, 64'd6);
        vecs[15] = mk(0, 0, 0, 0,  0, 0, 1, 1, 0, 32'hDDDDDDDD, 32'hEEEEEEEE, 64'd60, 64'd8);
        vecs[16] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 32'hE000000F, 0, 64'd124, 64'd10);
        vecs[17] = mk(1, 5, 255, 60, 1, 64'h17FC0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0,  0, 0, 1, 1, 0, 32'hDDDDDDDD, 32'hEEEEEEEE, 64'h17FFC, 64'd11);
        vecs[20] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 64'd0, 64'd13);
        vecs[23] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

        #12;
        chk("rst.en1", 64'(bus.fetchEnable1_o), 64'd0);
        chk("rst.en2", 64'(bus.fetchEnable2_o), 64'd0);
        chk("rst.miss", 64'(bus.cacheMiss_o), 64'd0);
        chk("rst.inst1", 64'(bus.fetchedInstruction1_o), 64'd0);
        chk("rst.id1", bus.fetchedInstMajorId1_o, 64'd0);
        chk("rst.maddr", bus.missedAddress_o, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].fe, vecs[i].tag, vecs[i].idx, vecs[i].off, vecs[i].upd, vecs[i].ua);
            tick();
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Refill idx0/idx1 with tag 0, fetch a hit, then hold it with fetchStall.
        drive(1'b0, 0, 0, 0, 1'b1, 64'd0);
        tick();
        drive(1'b1, 0, 0, 0, 1'b0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 0);
        tick();
        tick();
        chk("stl.en1", 64'(bus.fetchEnable1_o), 64'd1);
        chk("stl.inst1", 64'(bus.fetchedInstruction1_o), 64'hAAAAAAAA);
        chk("stl.inst2", 64'(bus.fetchedInstruction2_o), 64'hBBBBBBBB);
        chk("stl.id1", bus.fetchedInstMajorId1_o, 64'd13);
        bus.fetchStall_i = 1'b1;
        tick();
        tick();
        chk("stl.hold.en1", 64'(bus.fetchEnable1_o), 64'd1);
        chk("stl.hold.en2", 64'(bus.fetchEnable2_o), 64'd1);
        chk("stl.hold.id1", bus.fetchedInstMajorId1_o, 64'd13);
        bus.fetchStall_i = 1'b0;
        tick();
        chk("stl.drop.en1", 64'(bus.fetchEnable1_o), 64'd0);

        // Hit in flight to the outputs, then asynchronous reset between edges.
        drive(1'b1, 0, 0, 4, 1'b0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 0);
        tick();
        tick();
        chk("ar.en1", 64'(bus.fetchEnable1_o), 64'd1);
        chk("ar.inst1", 64'(bus.fetchedInstruction1_o), 64'hBBBBBBBB);
        chk("ar.inst2", 64'(bus.fetchedInstruction2_o), 64'hCCCCCCCC);
        chk("ar.id1", bus.fetchedInstMajorId1_o, 64'd15);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.now.en1", 64'(bus.fetchEnable1_o), 64'd0);
        chk("ar.now.en2", 64'(bus.fetchEnable2_o), 64'd0);
        chk("ar.now.inst1", 64'(bus.fetchedInstruction1_o), 64'd0);
        chk("ar.now.addr1", bus.fetchedAddress1_o, 64'd0);
        chk("ar.now.id1", bus.fetchedInstMajorId1_o, 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar.idle.en1", 64'(bus.fetchEnable1_o), 64'd0);
        drive(1'b1, 0, 0, 4, 1'b0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 0);
        tick();
        tick();
        chk("ar.re.miss", 64'(bus.cacheMiss_o), 64'd1);
        chk("ar.re.en1", 64'(bus.fetchEnable1_o), 64'd0);
        chk("ar.re.maddr", bus.missedAddress_o, 64'd4);
        chk("ar.re.mid", bus.missedInstMajorId_o, 64'd0);
        tick();
        chk("ar.re.pulse", 64'(bus.cacheMiss_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
